dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the core's memory stage. It consumes the load/store requests the memory stage produces.
- Owns the data RAM and applies a configurable number of wait states.
- Performs RV32I byte/half/word lane steering with sign/zero extension.
- Reports misaligned or illegal accesses. Holds the core via a busy/done handshake that feeds the hazard unit's stall logic.

---
 rtl/core_pkg.sv | 34 +++
 rtl/dmem_lane.sv | 47 ++++
 rtl/dmem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the data-memory path: funct3 codes, controller FSM
// states and the load/store legality check.
package core_pkg;

    localparam int WORD_SIZE_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unsigned variants exist only for loads; halves and words need natural alignment.
    function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational RV32I lane steering: byte enables and replicated write data for
// stores, lane select plus sign/zero extension for loads.
module dmem_lane
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rext
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be     = '0;
        wword  = wdata;
        byte_s = rword[{addr_lo, 3'b000} +: 8];
        half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
        rext   = rword;

        // Replicating the source across lanes lets the byte enable pick the target lane.
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wword = {2{wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase

        case (funct3)
            F3_B:    rext = 32'(byte_s);
            F3_H:    rext = 32'(half_s);
            F3_BU:   rext = {24'd0, byte_s};
            F3_HU:   rext = {16'd0, half_s};
            default: rext = rword;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: owns the data RAM, inserts WAIT_STATES cycles and
// reports completion via busy/done/fault. DMEM_MMIO_EN maps the top word to gpio_out.
module dmem_ctrl
    import core_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int ADDR_SIZE   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fault
`ifdef DMEM_MMIO_EN
    ,
    output logic [WORD_SIZE-1:0] gpio_out
`endif
);

    localparam int         DEPTH    = 2 ** (ADDR_SIZE - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 fpend_q, fpend_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    logic                 accept, legal, commit, is_mmio;
    logic                 cur_we;
    logic [2:0]           cur_f3;
    logic [ADDR_SIZE-1:0] cur_addr;
    logic [WORD_SIZE-1:0] cur_wdata;
    logic [ADDR_SIZE-3:0] widx;
    logic [WORD_SIZE-1:0] rword, wword, rext, merged;
    logic [3:0]           be;

`ifdef DMEM_MMIO_EN
    logic [WORD_SIZE-1:0] gpio_q, gpio_d;
    assign gpio_out = gpio_q;
`endif

    // The done cycle blocks acceptance so a request still held from the finished access is not reissued.
    assign accept = (state_q == ST_IDLE) && req && !done_q;

    // With zero wait states the access commits on the accepting edge, straight from the ports.
    always_comb begin
        cur_we    = (state_q == ST_IDLE) ? we     : we_q;
        cur_f3    = (state_q == ST_IDLE) ? funct3 : f3_q;
        cur_addr  = (state_q == ST_IDLE) ? addr   : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? wdata  : wdata_q;
    end

    assign widx   = cur_addr[ADDR_SIZE-1:2];
    assign legal  = access_ok(cur_we, cur_f3, cur_addr[1:0]);
    assign commit = (accept && legal && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 4'd0));

`ifdef DMEM_MMIO_EN
    assign is_mmio = (widx == '1);
    assign rword   = is_mmio ? gpio_q : mem[widx];
`else
    assign is_mmio = 1'b0;
    assign rword   = mem[widx];
`endif

    dmem_lane u_lane (
        .funct3  (cur_f3),
        .addr_lo (cur_addr[1:0]),
        .wdata   (cur_wdata),
        .rword   (rword),
        .be      (be),
        .wword   (wword),
        .rext    (rext)
    );

    always_comb begin
        merged = rword;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wword[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fpend_d = fpend_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
`ifdef DMEM_MMIO_EN
        gpio_d  = gpio_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fpend_d = !legal;
                    if (!legal || (WAIT_STATES == 0)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                fault_d = fpend_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            if (!cur_we) rdata_d = rext;
`ifdef DMEM_MMIO_EN
            else if (is_mmio) gpio_d = merged;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            fpend_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_MMIO_EN
            gpio_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fpend_q <= fpend_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
`ifdef DMEM_MMIO_EN
            gpio_q  <= gpio_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // RAM is never cleared; a store touches it only on its commit edge.
    always_ff @(posedge clk) begin
        if (rst && commit && cur_we && !is_mmio) mem[widx] <= merged;
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
module tb_dmem_ctrl;

    logic        clk, rst;
    logic        req1, req3, we;
    logic [2:0]  funct3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata3;
    logic        busy1, done1, fault1, busy3, done3, fault3;
`ifdef DMEM_MMIO_EN
    logic [31:0] gpio1, gpio3;
`endif

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.WORD_SIZE(32), .ADDR_SIZE(10), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1), .fault(fault1)
`ifdef DMEM_MMIO_EN
        , .gpio_out(gpio1)
`endif
    );

    dmem_ctrl #(.WORD_SIZE(32), .ADDR_SIZE(10), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata3), .busy(busy3), .done(done3), .fault(fault3)
`ifdef DMEM_MMIO_EN
        , .gpio_out(gpio3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat = edges after the accepting edge until done is seen; -1 if it never arrives.
    task automatic access(input bit sel, input logic w, input logic [2:0] f,
                          input logic [9:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic flt);
        @(negedge clk);
        while (sel ? done3 : done1) @(negedge clk);
        we = w; funct3 = f; addr = a; wdata = d;
        if (sel) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (sel ? done3 : done1) begin
                lat = i;
                break;
            end
        end
        rd  = sel ? rdata3 : rdata1;
        flt = sel ? fault3 : fault1;
        req1 = 1'b0; req3 = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata act=%h exp=%h", rdata1, 32'h0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy act=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done act=%b exp=0", done1); end
        checks++; if (fault1 !== 1'b0) begin errors++; $display("FAIL reset_fault act=%b exp=0", fault1); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic flt;
        access(0, 1'b1, 3'b010, 10'h010, 32'hDEADBEEF, lat, rd, flt);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency act=%0d exp=2", lat); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL sw_fault act=%b exp=0", flt); end
        access(0, 1'b0, 3'b010, 10'h010, 32'h0, lat, rd, flt);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency act=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data act=%h exp=%h", rd, 32'hDEADBEEF); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL lw_fault act=%b exp=0", flt); end
    endtask

    task automatic test_lanes();
        int lat; logic [31:0] rd; logic flt;
        access(0, 1'b0, 3'b000, 10'h013, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb act=%h exp=%h", rd, 32'hFFFFFFDE); end
        access(0, 1'b0, 3'b100, 10'h013, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu act=%h exp=%h", rd, 32'h000000DE); end
        access(0, 1'b0, 3'b001, 10'h012, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh act=%h exp=%h", rd, 32'hFFFFDEAD); end
        access(0, 1'b0, 3'b101, 10'h010, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu act=%h exp=%h", rd, 32'h0000BEEF); end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic flt;
        access(0, 1'b1, 3'b000, 10'h011, 32'h00000055, lat, rd, flt);
        access(0, 1'b0, 3'b010, 10'h010, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge act=%h exp=%h", rd, 32'hDEAD55EF); end
        access(0, 1'b1, 3'b001, 10'h01A, 32'h0000C3A7, lat, rd, flt);
        access(0, 1'b0, 3'b010, 10'h018, 32'h0, lat, rd, flt);
        checks++; if (rd[31:16] !== 16'hC3A7) begin errors++; $display("FAIL sh_upper act=%h exp=%h", rd[31:16], 16'hC3A7); end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic flt;
        access(0, 1'b0, 3'b010, 10'h010, 32'h0, lat, rd, flt);
        access(0, 1'b0, 3'b010, 10'h012, 32'h0, lat, rd, flt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lw_mis_latency act=%0d exp=1", lat); end
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL lw_mis_fault act=%b exp=1", flt); end
        checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL lw_mis_rdata act=%h exp=%h", rd, 32'hDEAD55EF); end
        access(0, 1'b1, 3'b010, 10'h020, 32'h11223344, lat, rd, flt);
        access(0, 1'b1, 3'b001, 10'h021, 32'h0000FFFF, lat, rd, flt);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL sh_mis_fault act=%b exp=1", flt); end
        access(0, 1'b0, 3'b010, 10'h020, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL sh_mis_nowrite act=%h exp=%h", rd, 32'h11223344); end
        access(0, 1'b0, 3'b011, 10'h040, 32'h0, lat, rd, flt);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL f3_011_fault act=%b exp=1", flt); end
        access(0, 1'b1, 3'b100, 10'h020, 32'h000000AA, lat, rd, flt);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL sbu_fault act=%b exp=1", flt); end
        access(0, 1'b0, 3'b010, 10'h020, 32'h0, lat, rd, flt);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL lw_legal_fault act=%b exp=0", flt); end
    endtask

    task automatic test_back_to_back();
        int seen, first;
        seen = 0; first = -1;
        @(negedge clk);
        while (done1) @(negedge clk);
        we = 1'b0; funct3 = 3'b010; addr = 10'h010; wdata = 32'h0;
        req1 = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy act=%b exp=1", busy1); end
            end
            if (done1) begin
                seen++;
                if (first < 0) first = i;
            end
            if (first >= 0 && i == first + 1) begin
                req1 = 1'b0;
                checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_reaccept busy act=%b exp=0", busy1); end
            end
        end
        req1 = 1'b0;
        checks++; if (seen !== 1) begin errors++; $display("FAIL b2b_done_count act=%0d exp=1", seen); end
        checks++; if (first !== 2) begin errors++; $display("FAIL b2b_done_edge act=%0d exp=2", first); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic flt;
        access(1, 1'b1, 3'b010, 10'h030, 32'hCAFEF00D, lat, rd, flt);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_sw_latency act=%0d exp=4", lat); end
        access(1, 1'b0, 3'b010, 10'h030, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws3_lw act=%h exp=%h", rd, 32'hCAFEF00D); end
        @(negedge clk);
        while (done3) @(negedge clk);
        we = 1'b1; funct3 = 3'b010; addr = 10'h030; wdata = 32'h12345678;
        req3 = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL abort_busy_pre act=%b exp=1", busy3); end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL abort_busy act=%b exp=0", busy3); end
        checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL abort_rdata act=%h exp=%h", rdata3, 32'h0); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL abort_rdata1 act=%h exp=%h", rdata1, 32'h0); end
        checks++; if (done3 !== 1'b0 || fault3 !== 1'b0) begin errors++; $display("FAIL abort_done_fault act=%b%b exp=00", done3, fault3); end
        req3 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        access(1, 1'b0, 3'b010, 10'h030, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_nowrite act=%h exp=%h", rd, 32'hCAFEF00D); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_lw_latency act=%0d exp=4", lat); end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        int lat; logic [31:0] rd; logic flt;
        access(0, 1'b1, 3'b010, 10'h3FC, 32'hA5A5A5A5, lat, rd, flt);
        checks++; if (gpio1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL mmio_sw act=%h exp=%h", gpio1, 32'hA5A5A5A5); end
        access(0, 1'b1, 3'b000, 10'h3FD, 32'h00000000, lat, rd, flt);
        checks++; if (gpio1 !== 32'hA5A500A5) begin errors++; $display("FAIL mmio_sb act=%h exp=%h", gpio1, 32'hA5A500A5); end
        access(0, 1'b0, 3'b010, 10'h3FC, 32'h0, lat, rd, flt);
        checks++; if (rd !== 32'hA5A500A5) begin errors++; $display("FAIL mmio_lw act=%h exp=%h", rd, 32'hA5A500A5); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (gpio1 !== 32'h0) begin errors++; $display("FAIL mmio_reset act=%h exp=%h", gpio1, 32'h0); end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b0; req1 = 1'b0; req3 = 1'b0; we = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_store_load();
        test_lanes();
        test_byte_store();
        test_faults();
        test_back_to_back();
        test_reset_abort();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
